// File: rtl/bird_pkg.sv
// Shared encodings for the bird_core processor: opcodes, ALU function codes
// and the control FSM state type.
package bird_pkg;

    localparam logic [3:0] OP_LDI  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_JZ   = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_ALU  = 4'h5;
    localparam logic [3:0] OP_PUSH = 4'h6;
    localparam logic [3:0] OP_POP  = 4'h7;
    localparam logic [3:0] OP_CALL = 4'h8;
    localparam logic [3:0] OP_RET  = 4'h9;
    localparam logic [3:0] OP_IRET = 4'hA;
    localparam logic [3:0] OP_EI   = 4'hB;
    localparam logic [3:0] OP_DI   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_AND = 4'h2;
    localparam logic [3:0] FN_OR  = 4'h3;
    localparam logic [3:0] FN_XOR = 4'h4;
    localparam logic [3:0] FN_NOT = 4'h5;
    localparam logic [3:0] FN_MOV = 4'h6;
    localparam logic [3:0] FN_SHL = 4'h7;
    localparam logic [3:0] FN_SHR = 4'h8;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_EXEC    = 3'd1,
        ST_IMM     = 3'd2,
        ST_MEMRD_S = 3'd3,
        ST_MEMWT_S = 3'd4,
        ST_POPRD   = 3'd5,
        ST_IRQPUSH = 3'd6,
        ST_HALT    = 3'd7
    } state_e;

endpackage

// File: rtl/bird_alu.sv
// Combinational ALU for bird_core; results truncate to DW, no carry out.
module bird_alu
    import bird_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    func,
    output logic [DW-1:0] result,
    output logic          zero
);

    // Function select; unassigned codes pass a through unchanged
    always_comb begin
        result = a;
        case (func)
            FN_ADD:  result = a + b;
            FN_SUB:  result = a - b;
            FN_AND:  result = a & b;
            FN_OR:   result = a | b;
            FN_XOR:  result = a ^ b;
            FN_NOT:  result = ~b;
            FN_MOV:  result = b;
            FN_SHL:  result = {b[DW-2:0], 1'b0};
            FN_SHR:  result = {1'b0, b[DW-1:1]};
            default: result = a;
        endcase
        zero = (result == {DW{1'b0}});
    end

endmodule

// File: rtl/bird_core.sv
// bird_core: multi-cycle CPU with one registered memory request port, wait
// states via MEM_RDY, a full-descending stack, one maskable interrupt and HALT.
module bird_core
    import bird_pkg::*;
#(
    parameter int DW  = 16,
    parameter int AW  = 16,
    parameter int RAW = 3,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}},
    parameter logic [AW-1:0] SP_INIT  = {AW{1'b1}},
    parameter logic [AW-1:0] IVEC     = AW'(32'd2)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] DATA_IN,
    input  logic          MEM_RDY,
    input  logic          IRQ,
    output logic [AW-1:0] ADDR_OUT,
    output logic [DW-1:0] DATA_OUT,
    output logic          MEMRD,
    output logic          MEMWT,
    output logic          IRQ_ACK,
    output logic          HALTED
);

    localparam int NREG = 2 ** RAW;
    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_r, state_s;
    logic [AW-1:0] pc_r, pc_s, sp_r, sp_s, addr_r, addr_s;
    logic [DW-1:0] dout_r, dout_s, wdata_s;
    logic [15:0]   ir_r, ir_s, iw_s;
    logic          ie_r, ie_s, zf_r, zf_s;
    logic          rd_r, rd_s, wt_r, wt_s, ack_r, ack_s, halted_r, halted_s;
    logic          we_s, go_fetch_s, stall_s;
    logic [DW-1:0] regs_r [NREG];

    logic [3:0]     op_s, func_s, ra_field_s, rb_field_s;
    logic [RAW-1:0] ra_s, rb_s;
    logic [DW-1:0]  ra_val_s, rb_val_s, alu_res_s;
    logic           alu_zero_s;
    logic           unused_s;

    // During FETCH completion decode straight from the bus, otherwise from ir
    assign iw_s       = (state_r == ST_FETCH) ? DATA_IN[15:0] : ir_r;
    assign op_s       = iw_s[15:12];
    assign func_s     = iw_s[11:8];
    assign rb_field_s = iw_s[7:4];
    assign ra_field_s = iw_s[3:0];
    assign ra_s       = ra_field_s[RAW-1:0];
    assign rb_s       = rb_field_s[RAW-1:0];
    assign ra_val_s   = regs_r[ra_s];
    assign rb_val_s   = regs_r[rb_s];
    assign stall_s    = (rd_r | wt_r) & ~MEM_RDY;
    assign unused_s   = ^{ra_field_s, rb_field_s};

    bird_alu #(.DW(DW)) u_alu (
        .a      (ra_val_s),
        .b      (rb_val_s),
        .func   (func_s),
        .result (alu_res_s),
        .zero   (alu_zero_s)
    );

    // Next-state, datapath updates and the next registered bus request
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        sp_s       = sp_r;
        ie_s       = ie_r;
        zf_s       = zf_r;
        ir_s       = ir_r;
        addr_s     = addr_r;
        dout_s     = dout_r;
        rd_s       = rd_r;
        wt_s       = wt_r;
        ack_s      = 1'b0;
        halted_s   = halted_r;
        we_s       = 1'b0;
        wdata_s    = {DW{1'b0}};
        go_fetch_s = 1'b0;
        if (stall_s) begin
            state_s = state_r;
        end else begin
            rd_s = 1'b0;
            wt_s = 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (!rd_r) begin
                        go_fetch_s = 1'b1;
                    end else begin
                        ir_s = DATA_IN[15:0];
                        pc_s = pc_r + ONE_A;
                        case (op_s)
                            OP_LDI, OP_JZ, OP_JMP, OP_CALL: begin
                                state_s = ST_IMM;
                                rd_s    = 1'b1;
                                addr_s  = pc_r + ONE_A;
                            end
                            OP_LD: begin
                                state_s = ST_MEMRD_S;
                                rd_s    = 1'b1;
                                addr_s  = rb_val_s[AW-1:0];
                            end
                            OP_ST: begin
                                state_s = ST_MEMWT_S;
                                wt_s    = 1'b1;
                                addr_s  = rb_val_s[AW-1:0];
                                dout_s  = ra_val_s;
                            end
                            OP_PUSH: begin
                                state_s = ST_MEMWT_S;
                                wt_s    = 1'b1;
                                addr_s  = sp_r - ONE_A;
                                dout_s  = ra_val_s;
                            end
                            OP_POP, OP_RET, OP_IRET: begin
                                state_s = ST_POPRD;
                                rd_s    = 1'b1;
                                addr_s  = sp_r;
                            end
                            OP_HALT: begin
                                state_s  = ST_HALT;
                                halted_s = 1'b1;
                            end
                            default: state_s = ST_EXEC;
                        endcase
                    end
                end
                ST_IMM: begin
                    case (op_s)
                        OP_LDI: begin
                            we_s       = 1'b1;
                            wdata_s    = DATA_IN;
                            pc_s       = pc_r + ONE_A;
                            go_fetch_s = 1'b1;
                        end
                        OP_JZ: begin
                            pc_s       = zf_r ? DATA_IN[AW-1:0] : pc_r + ONE_A;
                            go_fetch_s = 1'b1;
                        end
                        OP_CALL: begin
                            // Return address is the word after the call target
                            pc_s               = DATA_IN[AW-1:0];
                            state_s            = ST_MEMWT_S;
                            wt_s               = 1'b1;
                            addr_s             = sp_r - ONE_A;
                            dout_s             = {DW{1'b0}};
                            dout_s[AW-1:0]     = pc_r + ONE_A;
                        end
                        default: begin
                            pc_s       = DATA_IN[AW-1:0];
                            go_fetch_s = 1'b1;
                        end
                    endcase
                end
                ST_MEMRD_S: begin
                    we_s       = 1'b1;
                    wdata_s    = DATA_IN;
                    go_fetch_s = 1'b1;
                end
                ST_MEMWT_S: begin
                    if (op_s == OP_PUSH || op_s == OP_CALL) begin
                        sp_s = sp_r - ONE_A;
                    end else begin
                        sp_s = sp_r;
                    end
                    go_fetch_s = 1'b1;
                end
                ST_POPRD: begin
                    sp_s = sp_r + ONE_A;
                    case (op_s)
                        OP_POP: begin
                            we_s    = 1'b1;
                            wdata_s = DATA_IN;
                        end
                        OP_RET:  pc_s = DATA_IN[AW-1:0];
                        OP_IRET: begin
                            pc_s = DATA_IN[AW-1:0];
                            ie_s = 1'b1;
                        end
                        default: pc_s = pc_r;
                    endcase
                    go_fetch_s = 1'b1;
                end
                ST_IRQPUSH: begin
                    sp_s       = sp_r - ONE_A;
                    pc_s       = IVEC;
                    go_fetch_s = 1'b1;
                end
                ST_EXEC: begin
                    case (op_s)
                        OP_ALU: begin
                            we_s    = 1'b1;
                            wdata_s = alu_res_s;
                            zf_s    = alu_zero_s;
                        end
                        OP_EI:   ie_s = 1'b1;
                        OP_DI:   ie_s = 1'b0;
                        default: ie_s = ie_r;
                    endcase
                    go_fetch_s = 1'b1;
                end
                ST_HALT: halted_s = 1'b1;
                default: go_fetch_s = 1'b1;
            endcase

            // Instruction boundary: the interrupt check uses the registered IE,
            // so an EI only becomes visible one boundary later
            if (go_fetch_s) begin
                if (ie_r && IRQ) begin
                    state_s        = ST_IRQPUSH;
                    wt_s           = 1'b1;
                    rd_s           = 1'b0;
                    addr_s         = sp_s - ONE_A;
                    dout_s         = {DW{1'b0}};
                    dout_s[AW-1:0] = pc_s;
                    ack_s          = 1'b1;
                    ie_s           = 1'b0;
                end else begin
                    state_s = ST_FETCH;
                    rd_s    = 1'b1;
                    wt_s    = 1'b0;
                    addr_s  = pc_s;
                end
            end else begin
                ack_s = 1'b0;
            end
        end
    end

    // Control state, pointers, flags and registered bus outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r  <= ST_FETCH;
            pc_r     <= RESET_PC;
            sp_r     <= SP_INIT;
            ie_r     <= 1'b0;
            zf_r     <= 1'b0;
            ir_r     <= 16'h0000;
            addr_r   <= {AW{1'b0}};
            dout_r   <= {DW{1'b0}};
            rd_r     <= 1'b0;
            wt_r     <= 1'b0;
            ack_r    <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            sp_r     <= sp_s;
            ie_r     <= ie_s;
            zf_r     <= zf_s;
            ir_r     <= ir_s;
            addr_r   <= addr_s;
            dout_r   <= dout_s;
            rd_r     <= rd_s;
            wt_r     <= wt_s;
            ack_r    <= ack_s;
            halted_r <= halted_s;
        end
    end

    // Register file; all writes target the rA field
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (we_s) begin
            regs_r[ra_s] <= wdata_s;
        end else begin
            regs_r[ra_s] <= regs_r[ra_s];
        end
    end

    assign ADDR_OUT = addr_r;
    assign DATA_OUT = dout_r;
    assign MEMRD    = rd_r;
    assign MEMWT    = wt_r;
    assign IRQ_ACK  = ack_r;
    assign HALTED   = halted_r;

endmodule

// File: tb/tb_bird_core.sv
// Directed self-checking bench for bird_core with a behavioural shared memory.
module tb_bird_core;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] DATA_IN;
    logic        MEM_RDY = 1'b1;
    logic        IRQ = 1'b0;
    logic [15:0] ADDR_OUT;
    logic [15:0] DATA_OUT;
    logic        MEMRD, MEMWT, IRQ_ACK, HALTED;

    logic [15:0] mem [0:65535];
    logic        load_prog = 1'b1;
    logic [15:0] last_wa = 16'h0000;
    logic [15:0] last_wd = 16'h0000;
    int          ack_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    bird_core dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .DATA_IN  (DATA_IN),
        .MEM_RDY  (MEM_RDY),
        .IRQ      (IRQ),
        .ADDR_OUT (ADDR_OUT),
        .DATA_OUT (DATA_OUT),
        .MEMRD    (MEMRD),
        .MEMWT    (MEMWT),
        .IRQ_ACK  (IRQ_ACK),
        .HALTED   (HALTED)
    );

    always #5 CLK = ~CLK;

    assign DATA_IN = mem[ADDR_OUT];

    // Memory: program image load, then completed writes
    always @(posedge CLK) begin
        if (load_prog) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
            mem[16'h0000] <= 16'h4000; mem[16'h0001] <= 16'h0040;
            mem[16'h0002] <= 16'hD000; mem[16'h0003] <= 16'hD000;
            mem[16'h0004] <= 16'hA000;
            mem[16'h0010] <= 16'h8000; mem[16'h0011] <= 16'h0100;
            mem[16'h0012] <= 16'hB000; mem[16'h0013] <= 16'hD000;
            mem[16'h0014] <= 16'hD000; mem[16'h0015] <= 16'hF000;
            mem[16'h0020] <= 16'h1023;
            mem[16'h0021] <= 16'h0001; mem[16'h0022] <= 16'hAAAA;
            mem[16'h0023] <= 16'h6001; mem[16'h0024] <= 16'h7004;
            mem[16'h0025] <= 16'h4000; mem[16'h0026] <= 16'h0010;
            mem[16'h0040] <= 16'h0001; mem[16'h0041] <= 16'h1234;
            mem[16'h0042] <= 16'h0002; mem[16'h0043] <= 16'h1234;
            mem[16'h0044] <= 16'h5121;
            mem[16'h0045] <= 16'h3000; mem[16'h0046] <= 16'h0020;
            mem[16'h0100] <= 16'h9000;
            mem[16'h1234] <= 16'hBEEF;
        end else if (MEMWT && MEM_RDY) begin
            mem[ADDR_OUT] <= DATA_OUT;
            last_wa       <= ADDR_OUT;
            last_wd       <= DATA_OUT;
        end
    end

    // Count cycles in which IRQ_ACK is high
    always @(negedge CLK) begin
        if (IRQ_ACK) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fetch(input logic [15:0] a, input string tag);
        int n = 0;
        while (!(MEMRD && ADDR_OUT == a) && n < 200) begin
            tick();
            n++;
        end
        check(tag, {31'd0, (MEMRD && ADDR_OUT == a)}, 32'd1);
    endtask

    initial begin
        int n;
        int busy;
        // Reset and program load
        tick();
        load_prog = 1'b0;
        check("reset_memrd", {31'd0, MEMRD}, 32'd0);
        check("reset_memwt", {31'd0, MEMWT}, 32'd0);
        check("reset_addr", ADDR_OUT, 32'h0);
        check("reset_halted", {31'd0, HALTED}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        check("first_fetch_rd", {31'd0, MEMRD}, 32'd1);
        check("first_fetch_addr", ADDR_OUT, 32'h0);
        tick();
        check("jmp_imm_addr", ADDR_OUT, 32'h1);
        tick();
        check("jmp_target_addr", ADDR_OUT, 32'h40);

        // LDI/LDI/SUB then JZ taken
        wait_fetch(16'h0020, "jz_taken_fetch");
        check("sub_r1", dut.regs_r[1], 32'h0);
        check("sub_r2", dut.regs_r[2], 32'h1234);
        check("sub_zf", {31'd0, dut.zf_r}, 32'd1);

        // LD r3,[r2] with three wait states
        tick();
        check("ld_addr", ADDR_OUT, 32'h1234);
        MEM_RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ld_wait_addr", ADDR_OUT, 32'h1234);
            check("ld_wait_rd", {31'd0, MEMRD}, 32'd1);
        end
        check("ld_wait_r3_old", dut.regs_r[3], 32'h0);
        MEM_RDY = 1'b1;
        tick();
        check("ld_r3", dut.regs_r[3], 32'hBEEF);
        check("ld_next_fetch", ADDR_OUT, 32'h21);

        // PUSH r1 / POP r4
        wait_fetch(16'h0024, "push_done");
        check("push_wa", last_wa, 32'hFFFE);
        check("push_wd", last_wd, 32'hAAAA);
        check("push_sp", dut.sp_r, 32'hFFFE);
        wait_fetch(16'h0025, "pop_done");
        check("pop_r4", dut.regs_r[4], 32'hAAAA);
        check("pop_sp", dut.sp_r, 32'hFFFF);

        // CALL 0x0100 from 0x0010, RET
        wait_fetch(16'h0100, "call_target");
        check("call_wa", last_wa, 32'hFFFE);
        check("call_wd", last_wd, 32'h0012);
        check("call_sp", dut.sp_r, 32'hFFFE);
        wait_fetch(16'h0012, "ret_fetch");
        check("ret_sp", dut.sp_r, 32'hFFFF);

        // EI then interrupt
        IRQ = 1'b1;
        n = 0;
        while (!IRQ_ACK && n < 20) begin
            tick();
            n++;
        end
        check("irq_ack_seen", {31'd0, IRQ_ACK}, 32'd1);
        check("irq_push_wt", {31'd0, MEMWT}, 32'd1);
        check("irq_push_addr", ADDR_OUT, 32'hFFFE);
        check("irq_push_data", DATA_OUT, 32'h0014);
        check("irq_ie_clear", {31'd0, dut.ie_r}, 32'd0);
        tick();
        check("irq_ack_pulse", {31'd0, IRQ_ACK}, 32'd0);
        check("irq_vec_rd", {31'd0, MEMRD}, 32'd1);
        check("irq_vec_addr", ADDR_OUT, 32'h2);
        wait_fetch(16'h0004, "isr_iret_fetch");
        IRQ = 1'b0;
        check("irq_ack_count", ack_cnt, 32'd1);
        wait_fetch(16'h0014, "iret_resume");
        check("iret_ie", {31'd0, dut.ie_r}, 32'd1);
        check("iret_sp", dut.sp_r, 32'hFFFF);

        // HALT
        n = 0;
        while (!HALTED && n < 20) begin
            tick();
            n++;
        end
        check("halted", {31'd0, HALTED}, 32'd1);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (MEMRD || MEMWT || !HALTED) busy++;
        end
        check("halt_quiet", busy, 32'd0);

        // Reset release, run to PUSH, then reset in the middle of the write
        RESET = 1'b1;
        #1;
        check("rst_halted_clear", {31'd0, HALTED}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        check("rerun_fetch_addr", ADDR_OUT, 32'h0);
        wait_fetch(16'h0023, "rerun_push_fetch");
        tick();
        check("midwr_wt", {31'd0, MEMWT}, 32'd1);
        check("midwr_addr", ADDR_OUT, 32'hFFFE);
        MEM_RDY = 1'b0;
        tick();
        check("midwr_hold", {31'd0, MEMWT}, 32'd1);
        RESET = 1'b1;
        #1;
        check("midwr_rst_wt", {31'd0, MEMWT}, 32'd0);
        check("midwr_rst_rd", {31'd0, MEMRD}, 32'd0);
        check("midwr_rst_addr", ADDR_OUT, 32'h0);
        check("midwr_rst_data", DATA_OUT, 32'h0);
        MEM_RDY = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        check("post_rst_rd", {31'd0, MEMRD}, 32'd1);
        check("post_rst_addr", ADDR_OUT, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bird_core.md
# bird_core

Parametrised multi-cycle processor core: the next generation of the team's bird CPU. It is generalised in data/address width and register count. It adds a memory ready handshake for wait states, a full-descending stack with PUSH/POP/CALL/RET, a single maskable interrupt with IRET, and HALT. It sits between the instruction/data memory (single shared bus) and the board top; all memory traffic goes through one registered request port.

## Interface
- DW, 16: data/register width; instruction occupies DATA_IN[15:0], DW >= 16.
- AW, 16: address width; AW <= DW.
- RAW, 3: register index width (2^RAW registers); RAW <= 4.
- RESET_PC, 0: PC after reset.
- SP_INIT, 2^AW-1: stack pointer after reset.
- IVEC, 2: interrupt vector address.
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DATA_IN  in  DW  read data, sampled when MEM_RDY=1 during a read.
- MEM_RDY  in  1  access completes on a rising edge where MEM_RDY=1.
- IRQ  in  1  level interrupt request.
- ADDR_OUT  out  AW  access address; reset 0.
- DATA_OUT  out  DW  write data; reset 0.
- MEMRD  out  1  read request; reset 0.
- MEMWT  out  1  write request; reset 0.
- IRQ_ACK  out  1  one-cycle pulse on interrupt entry; reset 0.
- HALTED  out  1  high in HALT state; reset 0.

## Operation
- Encoding: op=ir[15:12], func=ir[11:8], rB=ir[7:4], rA=ir[3:0]. Only the low RAW bits of the register fields are used.
- Opcodes:
  - 0 LDI: rA<=next word.
  - 1 LD: rA<=mem[rB].
  - 2 ST: mem[rB]<=rA.
  - 3 JZ: if ZF, pc<=next word; else skip the word.
  - 4 JMP: pc<=next word (absolute).
  - 5 ALU: rA<=rA func rB, ZF<=(result==0).
  - 6 PUSH rA.
  - 7 POP rA.
  - 8 CALL: push return pc, pc<=next word.
  - 9 RET.
  - A IRET: pop pc, IE<=1.
  - B EI. C DI.
  - F HALT.
  - D, E: NOP.
- ALU func codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 NOT rB, 6 MOV rB, 7 SHL1 rB, 8 SHR1 rB (logical).
  - 9-F pass rA unchanged.
  - All results are truncated to DW; no carry flag.
- Only ALU instructions update ZF.
- Stack is full-descending, pre-decrement push (SP<=SP-1, mem[SP-1]<=data); pop reads mem[SP] then SP<=SP+1. SP wraps modulo 2^AW with no fault.
- CALL pushes the address after the target word.
- Interrupt:
  - Taken only in FETCH entry when IE=1 and IRQ=1.
  - Entry pushes pc, clears IE, sets pc<=IVEC and pulses IRQ_ACK.
  - IE resets to 0.
- Addresses are the low AW bits of register/pc values. PC increments wrap modulo 2^AW.
- HALT is left only by RESET.

## Timing
- States: FETCH, EXEC, IMM, MEMRD_S, MEMWT_S, POPRD, IRQPUSH, HALT.
- Bus request outputs are registered. They are set on the edge entering a bus state and held stable until the completing edge (MEM_RDY=1), where they drop unless the next state also accesses memory. With MEM_RDY=0, all state and outputs hold.
- Per-instruction sequence and cycle count at zero wait:
  - LDI, JZ, JMP: FETCH->IMM, 2 cycles.
  - CALL: FETCH->IMM->MEMWT_S, 3 cycles.
  - LD: FETCH->MEMRD_S, 2 cycles.
  - ST, PUSH: FETCH->MEMWT_S, 2 cycles.
  - POP, RET, IRET: FETCH->POPRD, 2 cycles.
  - ALU, EI, DI, NOP: FETCH->EXEC, 2 cycles.
  - Interrupt entry: IRQPUSH, 1 cycle, then FETCH at IVEC.
- Interrupt check happens before the FETCH request. EI takes effect for the check after the next instruction boundary.
- Register writes and ZF update occur on the completing edge of the last state.
- RESET mid-access: all outputs clear immediately, and state returns to FETCH at RESET_PC on the first edge after release.

## Structure
- Package bird_pkg: opcode constants, ALU func constants, state encoding.
- Sub-module bird_alu: combinational; inputs a, b, func; outputs result and zero; parametrised by DW.
- Core contains the FSM, register file, pc, SP, IE and ZF.

## Test plan
- Reset with RESET_PC=0: MEMRD=1, ADDR_OUT=0 on first edge after release. LDI r1,0x1234; LDI r2,0x1234; ALU SUB r1,r2 -> r1=0, ZF=1. JZ 0x0020 -> next fetch at 0x0020.
- Wait states: MEM_RDY held low for 3 cycles during LD r3,[r2] with mem=0xBEEF. Required: ADDR_OUT and MEMRD stable throughout; r3=0xBEEF one edge after MEM_RDY=1.
- Stack with SP_INIT=0xFFFF: PUSH r1=0xAAAA writes 0xAAAA at 0xFFFE, SP=0xFFFE. POP r4 gives r4=0xAAAA, SP=0xFFFF.
- CALL at 0x0010 (target 0x0100): MEMWT of 0x0012 at 0xFFFE; pc=0x0100. RET: next fetch at 0x0012.
- Interrupt: EI, then IRQ=1 -> IRQ_ACK pulses once, return pc pushed, fetch at IVEC=2, IE=0. With IRQ still high, no re-entry. IRET resumes at the saved pc.
- HALT -> HALTED=1 with no bus requests for 20 cycles. RESET asserted mid-write -> MEMWT drops immediately.
